fetch_prefetch_queue: RTL and testbench

Prefetching instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues sequential 32-bit fetch requests to a variable-latency instruction memory. Returned words are buffered in a small in-order queue, and the queue presents one instruction per cycle to decode under the pipeline's stall signal. A taken branch redirects the PC, flushes the queue and discards any responses still in flight.

---
 rtl/fetch_prefetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_prefetch_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Prefetching instruction-fetch front end: owns the PC, keeps imem requests in flight and buffers words in order.
// Build option: define PREFETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [63:0] branch_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instruction
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTSTANDING);

    logic [63:0]   pc;
    logic [31:0]   data_q [DEPTH];
    logic [63:0]   tag_q  [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tag_wptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          resp_live;
    logic          resp_keep;
    logic          bypass_hit;
    logic          bypass_take;
    logic          push;
    logic          pop;
    logic          queued;

    // Outstanding requests reserve their queue slot up front, so a response always has room.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = reset && !branch_taken && (outstanding < MAX_W) && (occupancy < DEPTH_W);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;

    assign resp_live = reset && imem_rvalid && (outstanding != '0);
    assign resp_keep = resp_live && !branch_taken && (drop_cnt == '0);
    assign queued    = (count != '0);

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = resp_keep && !queued;
`else
    assign bypass_hit = 1'b0;
`endif

    assign bypass_take = bypass_hit && !stall;
    assign push        = resp_keep && !bypass_take;
    assign pop         = queued && !stall && !branch_taken;
    assign tail        = head + count[PW-1:0];

    // Tags and data share the head pointer; a bypassed word still retires its tag.
    assign if_valid       = queued || bypass_hit;
    assign if_pc          = if_valid ? tag_q[head] : '0;
    assign if_instruction = queued ? data_q[head] : (bypass_hit ? imem_rdata : '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            head        <= '0;
            tag_wptr    <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(resp_live);
            if (branch_taken) begin
                pc       <= branch_addr;
                head     <= '0;
                tag_wptr <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(resp_live);
            end else begin
                if (accept) begin
                    pc       <= pc + 64'd4;
                    tag_wptr <= tag_wptr + PW'(1);
                end
                if (resp_live && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                head  <= head + PW'(pop || bypass_take);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[tag_wptr] <= pc;
        end
        if (push) begin
            data_q[tail] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: vector table, directed corner sequences and a randomized run against a queue model.
module tb_fetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [63:0] branch_addr;
    logic        stall;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instruction;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instruction(if_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int n_consumed = 0;
    bit magic  = 1'b0;
    bit chk_en = 1'b0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (magic && a == 64'h20) return 32'h00500093;
        return a[33:2];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // In-order memory with a programmable latency, reset together with the front end.
    typedef struct { logic [63:0] addr; int ready_at; } mreq_t;
    mreq_t memq[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (memq.size() > 0 && memq[0].ready_at <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(memq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    // Reference model: buffered words, pending tags in fetch order, and counts.
    typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
    ent_t        bufq[$];
    logic [63:0] tagq[$];
    int          m_out  = 0;
    int          m_drop = 0;
    logic [63:0] m_pc      = RESET_PC;
    logic [63:0] stream_pc = RESET_PC;

    always @(negedge clk) begin : model_b
        bit          acc, rv, keep, byp, byp_take, pop;
        bit          exp_valid, exp_req;
        logic [63:0] exp_pc, t;
        logic [31:0] exp_ins;
        exp_req  = reset && !branch_taken && (m_out < MAX_OUT) && (bufq.size() + m_out < DEPTH);
        rv       = reset && imem_rvalid && (m_out > 0);
        keep     = rv && !branch_taken && (m_drop == 0);
        byp      = BYPASS && keep && (bufq.size() == 0);
        byp_take = byp && !stall;
        pop      = (bufq.size() > 0) && !stall && !branch_taken;
        exp_valid = (bufq.size() > 0) || byp;
        exp_pc  = '0;
        exp_ins = '0;
        if (bufq.size() > 0) begin
            exp_pc  = bufq[0].pc;
            exp_ins = bufq[0].ins;
        end else if (byp && tagq.size() > 0) begin
            exp_pc  = tagq[0];
            exp_ins = imem_rdata;
        end
        if (chk_en) begin
            check("m_valid", 64'(if_valid), 64'(exp_valid));
            check("m_pc", if_pc, exp_pc);
            check("m_ins", 64'(if_instruction), 64'(exp_ins));
            check("m_req", 64'(imem_req), 64'(exp_req));
            if (exp_req) check("m_addr", imem_addr, m_pc);
            if (pop || byp_take) begin
                check("stream_pc", if_pc, stream_pc);
                check("stream_ins", 64'(if_instruction), 64'(mem_word(stream_pc)));
                n_consumed++;
            end
        end
        acc = exp_req && imem_ready;
        if (!reset) begin
            bufq.delete();
            tagq.delete();
            memq.delete();
            m_out = 0;
            m_drop = 0;
            m_pc = RESET_PC;
            stream_pc = RESET_PC;
        end else begin
            if (imem_req && imem_ready) memq.push_back('{imem_addr, cyc + lat});
            if (imem_rvalid && memq.size() > 0) memq.delete(0);
            if (pop) bufq.delete(0);
            if (keep && tagq.size() > 0) begin
                t = tagq.pop_front();
                if (!byp_take) bufq.push_back('{t, imem_rdata});
            end
            if (pop || byp_take) stream_pc = stream_pc + 64'd4;
            if (rv && m_drop > 0 && !branch_taken) m_drop--;
            m_out = m_out + (acc ? 1 : 0) - (rv ? 1 : 0);
            if (branch_taken) begin
                bufq.delete();
                tagq.delete();
                m_drop = m_out;
                m_pc = branch_addr;
                stream_pc = branch_addr;
            end else if (acc) begin
                tagq.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
        end
    end

    typedef struct {
        logic        rst, br, stl, rdy;
        logic [63:0] baddr;
        logic        exp_req, exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_ins;
    } vec_t;
    vec_t vecs[18];

    task automatic set_vec(input int i, input logic stl, input logic req, input logic v,
                           input logic [63:0] p, input logic [31:0] ins);
        vecs[i] = '{1'b1, 1'b0, stl, 1'b1, 64'h0, req, v, p, ins};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string name, input logic [63:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (if_valid) found = 1'b1;
        end
        check({name, "_seen"}, 64'(found), 64'd1);
        if (found) begin
            check({name, "_pc"}, if_pc, exp_pc);
            check({name, "_ins"}, 64'(if_instruction), 64'(mem_word(exp_pc)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; branch_taken = 1'b0; branch_addr = '0; stall = 1'b0; imem_ready = 1'b0;
        // Fill stream, then a 6-cycle stall that saturates slot reservation.
        set_vec(0, 0, 1, 0, 0, 0);   set_vec(1, 0, 1, 0, 0, 0);
        set_vec(2, 0, 1, 1, 0, 0);   set_vec(3, 0, 1, 1, 4, 1);
        set_vec(4, 0, 1, 1, 8, 2);   set_vec(5, 0, 1, 1, 12, 3);
        set_vec(6, 1, 1, 1, 16, 4);  set_vec(7, 1, 1, 1, 16, 4);
        set_vec(8, 1, 0, 1, 16, 4);  set_vec(9, 1, 0, 1, 16, 4);
        set_vec(10, 1, 0, 1, 16, 4); set_vec(11, 1, 0, 1, 16, 4);
        set_vec(12, 0, 0, 1, 16, 4); set_vec(13, 0, 1, 1, 20, 5);
        set_vec(14, 0, 1, 1, 24, 6); set_vec(15, 0, 1, 1, 28, 7);
        set_vec(16, 0, 1, 1, 32, 8); set_vec(17, 0, 1, 1, 36, 9);
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
`ifndef PREFETCH_BYPASS_EN
        for (int i = 0; i < 18; i++) begin
            step();
            reset = vecs[i].rst; branch_taken = vecs[i].br; branch_addr = vecs[i].baddr;
            stall = vecs[i].stl; imem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_req", i), 64'(imem_req), 64'(vecs[i].exp_req));
            check($sformatf("vec%0d_valid", i), 64'(if_valid), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_ins", i), 64'(if_instruction), 64'(vecs[i].exp_ins));
        end
`endif

        // Two requests in flight, then redirect: both late words must be dropped.
        do_reset(); lat = 4; imem_ready = 1'b1;
        branch_taken = 1'b1; branch_addr = 64'h10;
        @(negedge clk); check("t3_redir_req", 64'(imem_req), 64'd0);
        step(); branch_taken = 1'b0;
        @(negedge clk); check("t3_req0", 64'(imem_req), 64'd1); check("t3_addr0", imem_addr, 64'h10);
        step();
        @(negedge clk); check("t3_req1", 64'(imem_req), 64'd1); check("t3_addr1", imem_addr, 64'h14);
        step(); branch_taken = 1'b1; branch_addr = 64'h100;
        @(negedge clk); check("t3_redir2_req", 64'(imem_req), 64'd0);
        step(); branch_taken = 1'b0;
        wait_valid("t3_first", 64'h100);
        wait_valid("t3_second", 64'h104);

        // Redirect in a cycle carrying a response with another request still pending.
        do_reset(); lat = 2; imem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (imem_rvalid && m_out > 1) break;
        end
        branch_taken = 1'b1; branch_addr = 64'h2000;
        @(negedge clk); check("t4_redir_req", 64'(imem_req), 64'd0);
        step(); branch_taken = 1'b0;
        wait_valid("t4_first", 64'h2000);

        // Reset while three entries are buffered.
        do_reset(); lat = 1; imem_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (bufq.size() == 3) break;
        end
        reset = 1'b0;
        @(negedge clk); check("t5_req_in_reset", 64'(imem_req), 64'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("t5_valid", 64'(if_valid), 64'd0); check("t5_ins", 64'(if_instruction), 64'd0);
        check("t5_req", 64'(imem_req), 64'd0);   check("t5_pc", if_pc, 64'd0);
        step(); reset = 1'b1; stall = 1'b0;
        @(negedge clk); check("t5_restart_req", 64'(imem_req), 64'd1);
        check("t5_restart_addr", imem_addr, RESET_PC);
        wait_valid("t5_restart", RESET_PC);

`ifdef PREFETCH_BYPASS_EN
        do_reset(); lat = 1; imem_ready = 1'b1; magic = 1'b1;
        branch_taken = 1'b1; branch_addr = 64'h20;
        step(); branch_taken = 1'b0;
        @(negedge clk); check("t6_req", 64'(imem_req), 64'd1); check("t6_addr", imem_addr, 64'h20);
        check("t6_empty", 64'(if_valid), 64'd0);
        step();
        @(negedge clk);
        check("t6_valid", 64'(if_valid), 64'd1); check("t6_pc", if_pc, 64'h20);
        check("t6_ins", 64'(if_instruction), 64'h00500093);
`endif

        // Randomized run; the model checks every cycle.
        do_reset(); magic = 1'b0; n_consumed = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(1, 4);
            stall = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 4) != 0);
            branch_taken = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) branch_addr = 64'hFFFF_FFFF_FFFF_FFF8;
            else branch_addr = {$urandom(), $urandom()} & ~64'h3;
            reset = !($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b1; branch_addr = 64'h4000;
        step(); branch_taken = 1'b0;
        wait_valid("drain", 64'h4000);
        check("rand_progress", 64'(n_consumed > 200), 64'd1);
        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
